// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//   Registered-output valid/ready stream FIFO. It absorbs the output of the
//   upstream delay stage and decouples it from the consumer. Both handshake
//   flags are plain registers, so ready_o never depends combinationally on
//   ready_i or valid_i. In steady state it moves one word per cycle.
//
// Parameters
//   width_p : data word width in bits (>=1)
//   depth_p : number of storage entries (power of two, >=2)
//
// Ports
//   clk_i    : clock, rising-edge active
//   reset_ni : asynchronous active-low reset, released synchronously
//   data_i   : write data from upstream
//   valid_i  : upstream presents a word on data_i
//   ready_o  : FIFO accepts a word this cycle (registered)
//   valid_o  : data_o holds a valid word (registered)
//   data_o   : head-of-FIFO word, read from storage registers only
//   ready_i  : downstream accepts data_o this cycle
//
// Optional build macro STREAM_FIFO_COUNT_EN adds:
//   count_o  : registered occupancy, 0..depth_p
//   hwm_o    : highest occupancy seen since reset
// ---------------------------------------------------------------------------
module stream_fifo #(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
`ifdef STREAM_FIFO_COUNT_EN
    ,
    output logic [$clog2(depth_p):0] count_o,
    output logic [$clog2(depth_p):0] hwm_o
`endif
);

    localparam int AW = $clog2(depth_p);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(depth_p);

    // Pointers carry one extra wrap bit so that full (difference depth_p)
    // and empty (difference 0) are distinguishable without a flag.
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]      wr_ptr_next, rd_ptr_next;
    logic [PW-1:0]      count_next;
    logic               push, pop;
    logic [width_p-1:0] mem [depth_p];

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        wr_ptr_next = wr_ptr + PW'(push);
        rd_ptr_next = rd_ptr + PW'(pop);
        count_next  = wr_ptr_next - rd_ptr_next;
    end

    // ready_o resets to 0 and rises on the first edge after release, because
    // count_next is 0 there and so differs from FULL_CNT.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_o <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            ready_o <= (count_next != FULL_CNT);
            valid_o <= (count_next != '0);
        end
    end

    // Storage is data only: no reset, written at the write index on push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Head word comes from storage only; there is no bypass from data_i.
    assign data_o = mem[rd_ptr[AW-1:0]];

`ifdef STREAM_FIFO_COUNT_EN
    function automatic logic [PW-1:0] max_cnt(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Occupancy never exceeds depth_p, so the high-water mark saturates there
    // without any explicit clamp.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_o <= '0;
            hwm_o   <= '0;
        end else begin
            count_o <= count_next;
            hwm_o   <= max_cnt(hwm_o, count_next);
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//   Directed and randomized bench for stream_fifo (width 8, depth 8). A queue
//   holds the words the FIFO should contain; the expected flags follow from
//   its length, and every pop is compared with its front entry.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset_ni;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         ready_i;
`ifdef STREAM_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count_o;
    logic [$clog2(DEPTH):0] hwm_o;
`endif

    stream_fifo #(.width_p(W), .depth_p(DEPTH)) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
`ifdef STREAM_FIFO_COUNT_EN
        ,
        .count_o (count_o),
        .hwm_o   (hwm_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [W-1:0] q[$];
    bit           rdy_en = 1'b0;   // first edge after reset release seen
    int           exp_hwm = 0;
    bit           last_push = 1'b0;
    int           popped = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return rdy_en && (q.size() != DEPTH);
    endfunction

    function automatic bit exp_valid();
        return q.size() != 0;
    endfunction

    task automatic model_reset();
        q.delete();
        rdy_en  = 1'b0;
        exp_hwm = 0;
    endtask

    // Inputs must already be driven. Checks the flags and the head word,
    // then advances one clock and updates the model.
    task automatic cycle();
        bit p_push, p_pop;
        chk("ready_o", ready_o, exp_ready());
        chk("valid_o", valid_o, exp_valid());
        p_push = valid_i && exp_ready();
        p_pop  = exp_valid() && ready_i;
        if (p_pop) chk("data_o", data_o, q[0]);
        @(posedge clk);
        #1;
        if (p_pop) begin
            void'(q.pop_front());
            popped++;
        end
        if (p_push) q.push_back(data_i);
        last_push = p_push;
        rdy_en = 1'b1;
        if (q.size() > exp_hwm) exp_hwm = q.size();
`ifdef STREAM_FIFO_COUNT_EN
        chk("count_o", count_o, q.size());
        chk("hwm_o", hwm_o, exp_hwm);
`endif
    endtask

    initial begin
        logic r_before;
        int   pushed;
        int   cyc;

        // Reset then idle
        reset_ni = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_i   = '0;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_hold", ready_o, 1'b0);
        reset_ni = 1'b1;
        model_reset();
        cycle();
        chk("idle_ready", ready_o, 1'b1);
        chk("idle_valid", valid_o, 1'b0);
`ifdef STREAM_FIFO_COUNT_EN
        chk("idle_count", count_o, 0);
`endif

        // Fill with ready_i low
        for (int i = 1; i <= DEPTH; i++) begin
            valid_i = 1'b1;
            data_i  = W'(i);
            cycle();
        end
        chk("full_ready", ready_o, 1'b0);
        data_i = 8'h09;
        cycle();
        cycle();
        chk("full_size", q.size(), DEPTH);
`ifdef STREAM_FIFO_COUNT_EN
        chk("full_count", count_o, DEPTH);
        chk("full_hwm", hwm_o, DEPTH);
`endif

        // Drain
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", data_o, i);
            cycle();
            if (i == 1) chk("drain_ready_back", ready_o, 1'b1);
        end
        chk("drain_empty", valid_o, 1'b0);

        // Streaming through several pointer wraps
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_i = W'(8'h40 + i);
            cycle();
            chk("stream_head", data_o, 8'h40 + i);
        end
        valid_i = 1'b0;
        cycle();
        chk("stream_empty", valid_o, 1'b0);

        // Random stall traffic with held valid/data
        pushed    = 0;
        cyc       = 0;
        popped    = 0;
        last_push = 1'b0;
        valid_i   = 1'b0;
        while (pushed < 1000 && cyc < 20000) begin
            r_before = ready_o;
            if (!valid_i || last_push) begin
                valid_i = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                data_i  = W'($urandom);
            end
            ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("ready_stable", ready_o, r_before);
            cycle();
            if (last_push) pushed++;
            cyc++;
        end
        chk("rand_pushed", pushed, 1000);
        valid_i = 1'b0;
        ready_i = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            cycle();
            cyc++;
        end
        chk("rand_popped", popped, 1000);
        chk("rand_empty", valid_o, 1'b0);

        // Mid-operation reset with 5 words stored
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = W'(8'h10 + i);
            cycle();
        end
        valid_i = 1'b0;
        chk("pre_rst_valid", valid_o, 1'b1);
        #2;
        reset_ni = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_ready", ready_o, 1'b0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        valid_i  = 1'b1;
        data_i   = 8'hAA;
        cycle();
        cycle();
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("post_rst_valid", valid_o, 1'b1);
        chk("post_rst_head", data_o, 8'hAA);
        cycle();
        chk("post_rst_empty", valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Registered-output, valid/ready stream FIFO.
- Sits directly downstream of the SRL delay buffer. It absorbs that stage's output and decouples it from the consumer.
- It breaks the combinational ready path: the upstream stage's ready_o follows its ready_i, and this block's ready_o is driven only from internal registers.
- Full throughput of one word per cycle in steady state.

Parameters:
- width_p, 8, data word width in bits (>=1).
- depth_p, 8, number of storage entries; power of two, >=2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_ni  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to clk_i.
- data_i  input  width_p  write data from upstream.
- valid_i  input  1  upstream has a word on data_i.
- ready_o  output  1  FIFO can accept a word this cycle.
- valid_o  output  1  data_o holds a valid word.
- data_o  output  width_p  head-of-FIFO word.
- ready_i  input  1  downstream accepts data_o this cycle.

Behaviour:
- Handshakes:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
- Pointers and count:
  - Read and write pointers are $clog2(depth_p)+1 bits wide. The MSB is the wrap bit, so full and empty are distinguished without a separate flag.
  - count = wr_ptr - rd_ptr, modulo 2^(log2(depth_p)+1), range 0..depth_p.
- Flag registers:
  - ready_o is a register. Next value = (count_next != depth_p).
  - valid_o is a register. Next value = (count_next != 0).
  - Neither output may depend combinationally on valid_i or ready_i.
- Storage:
  - depth_p x width_p register array, written at wr_ptr index on push.
  - data_o = mem[rd_ptr index], read combinationally from storage registers only (no path from data_i).
- Latency: a word pushed into an empty FIFO appears on data_o with valid_o=1 on the following cycle. There is no same-cycle bypass.
- Boundary conditions:
  - Empty (count=0): valid_o=0. data_o is don't-care; the bench must not check it. Push only.
  - Full (count=depth_p): ready_o=0. A push is impossible that cycle, even if pop=1. The freed slot is visible via ready_o=1 on the next cycle.
  - Simultaneous push and pop with 0<count<depth_p: both pointers advance and count is unchanged. Sustains 1 word/cycle indefinitely.
  - Wrap-around: pointers roll over from 2^(log2 depth+1)-1 to 0. Ordering is strictly FIFO across any number of wraps.
  - valid_i=1 while ready_o=0: the word is not taken. Upstream holds it per the valid/ready rule.
- Reset:
  - reset_ni=0 at any time, including mid-stream or when full, immediately gives:
    - rd_ptr=wr_ptr=0.
    - valid_o=0.
    - ready_o=0 while reset is asserted.
  - ready_o goes to 1 on the first clock edge after deassertion.
  - Storage contents are not reset.
  - All prior data is discarded.
- No state machine beyond the pointer/flag registers. Illegal states are unreachable by construction.

Optional Feature:
- Macro: STREAM_FIFO_COUNT_EN.
- Defined:
  - Adds output port count_o, width $clog2(depth_p)+1. It carries the registered occupancy, equal to count after the edge, and is reset to 0.
  - Adds output hwm_o, same width. It is the high-water mark: the maximum count since reset, saturating at depth_p.
- Undefined:
  - Neither port exists and no counter logic is synthesized.
  - Handshake behaviour is identical in both builds.

Test Plan:
- Reset then idle, depth_p=8:
  - During reset_ni=0: valid_o=0, ready_o=0.
  - One cycle after release: ready_o=1, valid_o=0.
  - With the feature: count_o=0.
- Fill: push 0x01..0x08 back-to-back with ready_i=0.
  - ready_o drops to 0 the cycle after the 8th push.
  - A 9th word 0x09 held on data_i is not accepted.
  - With the feature: count_o=8, hwm_o=8.
- Drain: after the fill, ready_i=1.
  - data_o sequence is 0x01..0x08 on consecutive cycles.
  - valid_o=0 after the 8th pop.
  - ready_o returns to 1 one cycle after the first pop.
- Streaming through wrap: valid_i=1 and ready_i=1 for 40 cycles with an incrementing counter as data.
  - After 1 cycle of latency, output equals input delayed by one, with no gaps or duplicates.
  - Pointers wrap at least twice.
- Random stall: random valid_i and ready_i at 50% each over 1000 words.
  - Output stream equals input stream in order (scoreboard).
  - ready_o never changes within a cycle in response to ready_i.
- Mid-operation reset: with 5 words stored, pulse reset_ni low between clock edges.
  - valid_o=0 immediately.
  - After release, the FIFO is empty; the next pushed word 0xAA is the first output.
